td4_sequencer: RTL

TD4_SEQUENCER -- requirements
Module: td4_sequencer

---
 rtl/td4_sequencer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/td4_sequencer.sv
// TD4 fetch/execute sequencer: fetches one instruction byte per FETCH, strobes the
// register/PC writes for exactly one EXEC cycle, and traps to a sticky FAULT on fetch timeout.
module td4_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       step,
  input  logic [3:0] pc,
  output logic       mem_req,
  output logic [3:0] mem_addr,
  input  logic       mem_ack,
  input  logic [7:0] mem_data,
  output logic [3:0] opcode,
  output logic [3:0] imm,
  output logic       c_flag,
  input  logic       sel_A,
  input  logic       sel_B,
  input  logic       sel_Out,
  input  logic       sel_PC,
  input  logic       carry_in,
  output logic       we_a,
  output logic       we_b,
  output logic       we_out,
  output logic       pc_load,
  output logic       pc_inc,
  output logic       busy,
  output logic       fault,
  output logic [7:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic [3:0] opcode_q, opcode_d;
  logic [3:0] imm_q, imm_d;
  logic       c_q, c_d;
  logic [7:0] ret_q, ret_d;
  logic       nop_op;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      opcode_q <= '0;
      imm_q    <= '0;
      c_q      <= 1'b0;
      ret_q    <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      opcode_q <= opcode_d;
      imm_q    <= imm_d;
      c_q      <= c_d;
      ret_q    <= ret_d;
    end
  end

  // The wait counter is only held while FETCH continues without ack, so every
  // FETCH entry (from IDLE or back-to-back from EXEC) starts it at zero.
  always_comb begin
    state_d  = state_q;
    wait_d   = '0;
    opcode_d = opcode_q;
    imm_d    = imm_q;
    c_d      = c_q;
    ret_d    = ret_q;
    case (state_q)
      S_IDLE: begin
        if (run || step) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) begin
          state_d  = S_EXEC;
          opcode_d = mem_data[7:4];
          imm_d    = mem_data[3:0];
        end else if (wait_q == 4'hF) begin
          state_d = S_FAULT;
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      S_EXEC: begin
        c_d     = carry_in;
        ret_d   = ret_q + 8'd1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  assign nop_op = opcode_q inside {4'b1000, 4'b1010, 4'b1100, 4'b1101};

  // Unused opcodes are forced to a plain PC increment whatever the decoder says.
  always_comb begin
    mem_req = 1'b0;
    busy    = 1'b0;
    fault   = 1'b0;
    we_a    = 1'b0;
    we_b    = 1'b0;
    we_out  = 1'b0;
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        busy    = 1'b1;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (nop_op) begin
          pc_inc = 1'b1;
        end else begin
          we_a    = ~sel_A;
          we_b    = ~sel_B;
          we_out  = ~sel_Out;
          pc_load = ~sel_PC;
          pc_inc  = sel_PC;
        end
      end
      S_FAULT: fault = 1'b1;
      default: ;
    endcase
  end

  assign mem_addr = pc;
  assign opcode   = opcode_q;
  assign imm      = imm_q;
  assign c_flag   = c_q;
  assign retired  = ret_q;

endmodule
